// File: rtl/axi_sram_slave.sv
// AXI3 slave that serves one read burst and one write burst concurrently from a single-port
// synchronous SRAM, sharing the port through a round-robin arbiter.
module axi_sram_slave #(
  parameter int unsigned MEM_AW = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [MEM_AW-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {RIdle, RIssue, RData} r_state_e;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

  r_state_e r_state_q, r_state_d;
  w_state_e w_state_q, w_state_d;

  logic [3:0]  r_id_q, w_id_q;
  logic [31:0] r_addr_q, w_addr_q;
  logic [7:0]  r_len_q, w_len_q, r_beat_q, w_beat_q;
  logic [2:0]  r_size_q, w_size_q;
  logic [1:0]  r_burst_q, w_burst_q;
  logic        r_err_q, w_err_q, w_slverr_q;
  logic        r_fresh_q;
  logic [31:0] r_hold_q;
  logic        last_gnt_w_q;

  logic rlast_int, req_r, req_w, gnt_r, gnt_w;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  logic unused_ok;
  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] sz,
                                            input logic [1:0] bu);
    return (bu == 2'b01) ? a + (32'd1 << sz) : a;
  endfunction

  assign rlast_int = (r_beat_q == r_len_q);

  // Errored bursts never touch the SRAM, so they never request the port.
  assign req_r = resetn && !r_err_q &&
                 ((r_state_q == RIssue) || ((r_state_q == RData) && rready && !rlast_int));
  assign req_w = resetn && !w_err_q && (w_state_q == WData) && wvalid;
  assign gnt_r = req_r && (!req_w || last_gnt_w_q);
  assign gnt_w = req_w && (!req_r || !last_gnt_w_q);

  assign ar_hs = arvalid && resetn && (r_state_q == RIdle);
  assign r_hs  = rready && resetn && (r_state_q == RData);
  assign aw_hs = awvalid && resetn && (w_state_q == WIdle);
  assign w_hs  = wvalid && resetn && (w_state_q == WData) && (w_err_q || gnt_w);
  assign b_hs  = bready && resetn && (w_state_q == WResp);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state_q    <= RIdle;
      w_state_q    <= WIdle;
      last_gnt_w_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      if (gnt_r) begin
        last_gnt_w_q <= 1'b0;
      end else if (gnt_w) begin
        last_gnt_w_q <= 1'b1;
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:  if (ar_hs) r_state_d = RIssue;
      RIssue: if (r_err_q || gnt_r) r_state_d = RData;
      RData: begin
        if (r_hs) begin
          if (rlast_int) begin
            r_state_d = RIdle;
          end else if (!(r_err_q || gnt_r)) begin
            r_state_d = RIssue;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle: if (aw_hs) w_state_d = WData;
      WData: if (w_hs && (wlast || (w_beat_q == w_len_q))) w_state_d = WResp;
      WResp: if (b_hs) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_err_q   <= 1'b0;
      r_fresh_q <= 1'b0;
      r_hold_q  <= '0;
    end else begin
      r_fresh_q <= gnt_r;
      if (r_fresh_q) r_hold_q <= sram_rdata;
      if (ar_hs) begin
        r_id_q    <= arid;
        r_addr_q  <= araddr;
        r_len_q   <= arlen;
        r_beat_q  <= '0;
        r_size_q  <= arsize;
        r_burst_q <= arburst;
        r_err_q   <= arburst[1] || (arsize > 3'd2);
      end else begin
        if (gnt_r) r_addr_q <= next_addr(r_addr_q, r_size_q, r_burst_q);
        if (r_hs) r_beat_q <= r_beat_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_id_q     <= '0;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_beat_q   <= '0;
      w_size_q   <= '0;
      w_burst_q  <= '0;
      w_err_q    <= 1'b0;
      w_slverr_q <= 1'b0;
    end else if (aw_hs) begin
      w_id_q     <= awid;
      w_addr_q   <= awaddr;
      w_len_q    <= awlen;
      w_beat_q   <= '0;
      w_size_q   <= awsize;
      w_burst_q  <= awburst;
      w_err_q    <= awburst[1] || (awsize > 3'd2);
      w_slverr_q <= awburst[1] || (awsize > 3'd2);
    end else if (w_hs) begin
      w_addr_q <= next_addr(w_addr_q, w_size_q, w_burst_q);
      w_beat_q <= w_beat_q + 8'd1;
      // wlast disagreeing with the beat count ends the burst with an error.
      if (wlast != (w_beat_q == w_len_q)) w_slverr_q <= 1'b1;
    end
  end

  always_comb begin
    arready = resetn && (r_state_q == RIdle);
    awready = resetn && (w_state_q == WIdle);
    rvalid  = resetn && (r_state_q == RData);
    rlast   = rvalid && rlast_int;
    rid     = rvalid ? r_id_q : '0;
    rresp   = (rvalid && r_err_q) ? RespSlvErr : RespOkay;
    rdata   = '0;
    if (rvalid && !r_err_q) rdata = r_fresh_q ? sram_rdata : r_hold_q;
    wready  = resetn && (w_state_q == WData) && (w_err_q || gnt_w);
    bvalid  = resetn && (w_state_q == WResp);
    bid     = bvalid ? w_id_q : '0;
    bresp   = (bvalid && w_slverr_q) ? RespSlvErr : RespOkay;
    sram_en    = gnt_r || gnt_w;
    sram_we    = gnt_w ? wstrb : '0;
    sram_wdata = gnt_w ? wdata : '0;
    sram_addr  = '0;
    if (gnt_w) begin
      sram_addr = w_addr_q[MEM_AW+1:2];
    end else if (gnt_r) begin
      sram_addr = r_addr_q[MEM_AW+1:2];
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: a vector table of single-beat transfers plus hand-written
// sequences for bursts, stalls, arbitration conflicts, error responses and mid-burst reset.
module tb_axi_sram_slave;
  localparam int unsigned MemAw = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  logic [3:0] arid, rid, awid, wid, bid, wstrb, sram_we;
  logic [31:0] araddr, rdata, awaddr, wdata, sram_wdata, sram_rdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, arprot, awsize, awprot;
  logic [1:0] arburst, arlock, rresp, awburst, awlock, bresp;
  logic [3:0] arcache, awcache;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic wlast, wvalid, wready, bvalid, bready, sram_en;
  logic [MemAw-1:0] sram_addr;

  logic [31:0] mem [0:(1<<MemAw)-1];
  int checks = 0;
  int failures = 0;
  int en_count = 0;
  logic [31:0] wq [8];
  logic [31:0] rq [8];

  typedef struct {
    bit          wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;  // write data, or expected read data
    logic [3:0]  strb;
  } vec_t;
  vec_t vt [11];

  axi_sram_slave #(.MEM_AW(MemAw)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always @(posedge clk) begin
    if (sram_en) begin
      en_count <= en_count + 1;
      for (int b = 0; b < 4; b++) begin
        if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
      if (sram_we == 4'b0) sram_rdata <= mem[sram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input logic [2:0] size, input logic [3:0] strb,
                    input int last_at, input logic [1:0] exp_resp);
    int n;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); #1; n++; end
    chk("aw_ready", awready, 1);
    for (int k = 0; k <= last_at; k++) begin
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b1; wdata = wq[k]; wstrb = strb; wlast = (k == last_at);
      #1;
      n = 0;
      while (!wready && n < 20) begin @(negedge clk); #1; n++; end
      chk("w_ready", wready, 1);
    end
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    #1;
    chk("b_valid", bvalid, 1);
    chk("b_id", bid, id);
    chk("b_resp", bresp, exp_resp);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input logic [2:0] size, input logic [1:0] exp_resp,
                    input bit stall, input bit chk_lat);
    int n, k, cyc;
    logic [31:0] held;
    bit was_stalled;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); #1; n++; end
    chk("ar_ready", arready, 1);
    k = 0; cyc = 0; was_stalled = 1'b0; held = '0;
    while (k <= int'(len) && cyc < 100) begin
      @(negedge clk);
      arvalid = 1'b0;
      cyc++;
      rready = stall ? cyc[0] : 1'b1;
      #1;
      if (chk_lat && cyc == 1) chk("r_issue_en", sram_en, 1);
      if (rvalid) begin
        if (was_stalled) chk("r_hold", rdata, held);
        if (rready) begin
          if (chk_lat) chk("r_beat_time", cyc, k + 2);
          chk("r_data", rdata, rq[k]);
          chk("r_id", rid, id);
          chk("r_resp", rresp, exp_resp);
          chk("r_last", rlast, (k == int'(len)));
          k++;
          was_stalled = 1'b0;
        end else begin
          held = rdata;
          was_stalled = 1'b1;
        end
      end
    end
    chk("r_beats", k, int'(len) + 1);
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    int n0;
    vt[0]  = '{1'b1, 4'h1, 32'h0000_0014, 3'd2, 32'hDEAD_BEEF, 4'hF};
    vt[1]  = '{1'b0, 4'h3, 32'h0000_0014, 3'd2, 32'hDEAD_BEEF, 4'h0};
    vt[2]  = '{1'b1, 4'h2, 32'h0000_0020, 3'd2, 32'hAAAA_AAAA, 4'hF};
    vt[3]  = '{1'b1, 4'h4, 32'h0000_0020, 3'd2, 32'h1122_3344, 4'b0101};
    vt[4]  = '{1'b0, 4'h5, 32'h0000_0020, 3'd2, 32'hAA22_AA44, 4'h0};
    vt[5]  = '{1'b0, 4'h6, 32'h0004_0014, 3'd2, 32'hDEAD_BEEF, 4'h0};  // aliases word 5
    vt[6]  = '{1'b0, 4'h7, 32'h0000_0015, 3'd0, 32'hDEAD_BEEF, 4'h0};  // narrow: full word
    vt[7]  = '{1'b1, 4'h8, 32'h0000_0024, 3'd2, 32'h55AA_55AA, 4'hF};
    vt[8]  = '{1'b1, 4'h9, 32'h0000_0024, 3'd2, 32'hCAFE_F00D, 4'h0};
    vt[9]  = '{1'b0, 4'hA, 32'h0000_0024, 3'd2, 32'h55AA_55AA, 4'h0};
    vt[10] = '{1'b1, 4'hB, 32'h0000_0208, 3'd2, 32'h7777_7777, 4'hF};

    resetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = '0; arcache = '0;
    arprot = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0; awcache = '0;
    awprot = '0; awvalid = 1'b0; wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0;
    wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctrl", {arready, awready, rvalid, rlast, wready, bvalid, sram_en, sram_we}, 0);
    chk("rst_resp", {rid, rresp, bid, bresp}, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1;
    chk("rel_ready", {arready, awready}, 2'b11);

    for (int i = 0; i < 11; i++) begin
      if (vt[i].wr) begin
        wq[0] = vt[i].data;
        wr(vt[i].id, vt[i].addr, 8'd0, 2'b01, vt[i].size, vt[i].strb, 0, 2'b00);
      end else begin
        rq[0] = vt[i].data;
        rd(vt[i].id, vt[i].addr, 8'd0, 2'b01, vt[i].size, 2'b00, 1'b0, 1'b1);
      end
    end

    // INCR burst write then read back, streaming and with rready toggling.
    wq[0] = 32'h1111_0000; wq[1] = 32'h2222_0001; wq[2] = 32'h3333_0002; wq[3] = 32'h4444_0003;
    wr(4'h1, 32'h100, 8'd3, 2'b01, 3'd2, 4'hF, 3, 2'b00);
    for (int k = 0; k < 4; k++) rq[k] = wq[k];
    rd(4'h2, 32'h100, 8'd3, 2'b01, 3'd2, 2'b00, 1'b0, 1'b1);
    rd(4'h3, 32'h100, 8'd3, 2'b01, 3'd2, 2'b00, 1'b1, 1'b0);

    // FIXED burst: both beats land on the same word.
    wq[0] = 32'h1111_1111; wq[1] = 32'h2222_2222;
    wr(4'hD, 32'h40, 8'd1, 2'b00, 3'd2, 4'hF, 1, 2'b00);
    chk("fixed_word", mem[16], 32'h2222_2222);

    // Illegal read burst type: zeros, SLVERR, no SRAM traffic.
    rq[0] = '0; rq[1] = '0;
    n0 = en_count;
    rd(4'h4, 32'h14, 8'd1, 2'b10, 3'd2, 2'b10, 1'b0, 1'b0);
    chk("rerr_no_sram", en_count, n0);

    // Oversized write: accepted, SLVERR, memory untouched.
    wq[0] = 32'hFFFF_FFFF;
    wr(4'hC, 32'h14, 8'd0, 2'b01, 3'd3, 4'hF, 0, 2'b10);
    chk("werr_untouched", mem[5], 32'hDEAD_BEEF);

    // Early wlast on the second beat of a len=3 burst.
    wq[0] = 32'hA0A0_A0A0; wq[1] = 32'hA1A1_A1A1;
    wr(4'h9, 32'h200, 8'd3, 2'b01, 3'd2, 4'hF, 1, 2'b10);
    chk("early_w0", mem[32'h80], 32'hA0A0_A0A0);
    chk("early_w1", mem[32'h81], 32'hA1A1_A1A1);
    chk("early_w2", mem[32'h82], 32'h7777_7777);

    // Reset during beat 2 of a len=7 read.
    @(negedge clk);
    arid = 4'h2; araddr = 32'h100; arlen = 8'd7; arburst = 2'b01; arsize = 3'd2; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid_beat2", {rvalid, rdata}, {1'b1, 32'h2222_0001});
    resetn = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_ctrl", {arready, awready, rvalid, rlast, wready, bvalid, sram_en, sram_we}, 0);
    chk("mid_rst_data", {rdata, rid, rresp}, 0);
    resetn = 1'b1; rready = 1'b0;
    rq[0] = 32'hDEAD_BEEF;
    rd(4'h5, 32'h14, 8'd0, 2'b01, 3'd2, 2'b00, 1'b0, 1'b1);

    // AR and AW in the same cycle; last grant was a read, so write wins first.
    @(negedge clk);
    arid = 4'h6; araddr = 32'h14; arlen = 8'd0; arburst = 2'b01; arsize = 3'd2; arvalid = 1'b1;
    awid = 4'h7; awaddr = 32'h30; awlen = 8'd1; awburst = 2'b01; awsize = 3'd2; awvalid = 1'b1;
    #1;
    chk("cf_ready", {arready, awready}, 2'b11);
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; rready = 1'b1;
    wvalid = 1'b1; wdata = 32'h5A5A_0001; wstrb = 4'hF; wlast = 1'b0;
    #1;
    chk("cf_g1_write", {sram_en, sram_we, wready}, {1'b1, 4'hF, 1'b1});
    chk("cf_g1_addr", sram_addr, 16'h000C);
    @(negedge clk);
    wdata = 32'h5A5A_0002; wlast = 1'b1;
    #1;
    chk("cf_g2_read", {sram_en, sram_we, wready}, {1'b1, 4'h0, 1'b0});
    chk("cf_g2_addr", sram_addr, 16'h0005);
    @(negedge clk);
    #1;
    chk("cf_g3_write", wready, 1);
    chk("cf_r_beat", {rvalid, rlast, rid}, {1'b1, 1'b1, 4'h6});
    chk("cf_r_data", rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;
    #1;
    chk("cf_b", {bvalid, bid, bresp, rvalid}, {1'b1, 4'h7, 2'b00, 1'b0});
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("cf_mem0", mem[12], 32'h5A5A_0001);
    chk("cf_mem1", mem[13], 32'h5A5A_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI3-style slave responder that terminates the CPU's AXI master port (4-bit IDs, 32-bit data) and serves reads and writes from a single-port synchronous SRAM. It is the memory-side counterpart of the core's AXI bridge and is used as the simulation and FPGA backing store for both instruction and data traffic. One read burst and one write burst may be in flight concurrently, and they share the SRAM port through a round-robin arbiter.

## Interface
- MEM_AW, default 16: SRAM word-address width; byte address bits [MEM_AW+1:2] index memory, and higher bits are ignored (aliasing).
- clk  in  1  clock; all logic is on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  read address channel.
- arlock/arcache/arprot  in  2/4/3  accepted and ignored.
- arvalid  in  1; arready  out  1.
- rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1; rready  in  1.
- awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2; awlock/awcache/awprot are ignored.
- awvalid  in  1; awready  out  1.
- wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1; wready  out  1; wid is ignored.
- bid/bresp/bvalid  out  4/2/1; bready  in  1.
- sram_en  out  1: port access this cycle.
- sram_we  out  4: byte write enables; 0 means read.
- sram_addr  out  MEM_AW: word address.
- sram_wdata  out  32.
- sram_rdata  in  32: valid the cycle after a read with sram_en=1.

## Operation
- Read FSM states:
  - R_IDLE: arready=1.
  - On AR handshake, latch id, addr, len, size, burst and a beat counter, then go to R_ISSUE.
  - R_ISSUE: request the port. When granted, pulse sram_en with sram_we=0 and go to R_DATA.
  - R_DATA: rvalid=1 and rlast=(beat==len).
  - In R_DATA, rdata equals sram_rdata in the first cycle and is captured into a hold register. It comes from the hold register while rready=0.
  - On an R handshake with rlast=0, issue the next beat's read in that same cycle if granted and stay in R_DATA; if not granted, go to R_ISSUE.
  - On an R handshake with rlast=1, go to R_IDLE.
- Write FSM states:
  - W_IDLE: awready=1.
  - On AW handshake, latch the fields and go to W_DATA.
  - W_DATA: wready=1 only when granted this cycle.
  - Each W handshake drives sram_en=1, sram_we=wstrb, sram_wdata=wdata.
  - On a handshake with wlast=1, go to W_RESP.
  - W_RESP: bvalid=1 until bready, then go to W_IDLE.
- Address update after each beat:
  - INCR (2'b01): add (1<<size) bytes; 32-bit wrap is allowed.
  - FIXED (2'b00): address is unchanged.
- Error rules (SLVERR = 2'b10):
  - arburst/awburst equal to 2'b10 or 2'b11, or size > 2, gives SLVERR.
  - Errored reads still return len+1 beats with rdata=0 and perform no SRAM access.
  - Errored writes accept all beats with sram_we=0 and return bresp=SLVERR.
  - If wlast arrives at a beat other than len, the burst terminates there with bresp=SLVERR. Writes already performed stand.
  - Otherwise rresp/bresp=OKAY (2'b00).
- Narrow reads return the full addressed word; the master selects lanes.
- Arbiter:
  - The port is granted to a sole requester immediately.
  - On a simultaneous request, grant goes to the side not granted last time.
  - The last-grant bit resets to "read", so write wins the first conflict.

## Timing
- Reset values: every output is 0, including arready and awready while resetn=0. Both FSMs are in IDLE and the last-grant bit is set to read.
- arready/awready are 1 in the first cycle after reset release.
- Read latency without conflict:
  - AR handshake in cycle T.
  - sram_en in T+1.
  - rvalid with data in T+2.
- With rready held high, following beats arrive one per cycle.
- Write:
  - AW handshake in cycle T.
  - wready earliest in T+1.
  - One beat per granted cycle.
  - bvalid in the cycle after the wlast handshake.
- A conflict delays the losing side by exactly one cycle per lost arbitration.
- rdata, rid, rresp and rlast are held stable while rvalid=1 and rready=0. bid and bresp are held while bvalid=1.
- A write and a read to the same word in the same burst window are ordered by grant order only; there is no forwarding.
- resetn low mid-burst returns both FSMs to IDLE on the next edge. The in-flight burst is abandoned and no response is issued.

## Test plan
- Single read: write 0xDEADBEEF to word 5, then issue AR with araddr=0x14, len=0, id=3, rready=1 -> rvalid in T+2, rdata=0xDEADBEEF, rid=3, rlast=1, rresp=0.
- INCR read burst: len=3 from 0x100 (words 0x40..0x43), rready=1 -> 4 consecutive beats, rlast only on beat 4. Repeat with rready toggling 1/0 -> data held stable across stall cycles.
- Byte-strobe write: AW to 0x20, len=0, then W with wdata=0x11223344, wstrb=4'b0101 over old word 0xAAAAAAAA -> word becomes 0xAA22AA44, and bvalid arrives the cycle after wlast with bresp=0 and the matching bid.
- Conflict: AR and AW accepted in the same cycle -> the first grant goes to write and the next contested cycle to read. No beat is lost or duplicated.
- Errors:
  - arburst=2'b10 with len=1 -> 2 beats of rdata=0 with rresp=2'b10.
  - Write len=3 with wlast on beat 2 -> bresp=2'b10, and words 0–1 are written.
- Reset mid-burst: drop resetn during beat 2 of a len=7 read -> all outputs are 0 next cycle, and a new read succeeds after reset release.
